iq_stream_packer: RTL and testbench
===================================

// Module: iq_stream_packer
// PURPOSE
//  Downstream of transmitter. Captures each parallel I/Q sample pair (signal_sca_i/q) into a
//  small pair FIFO. Emits one 16-bit word per handshake, interleaved I then Q, toward the
//  sample sink (DAC/host stream). Counts one frame of FRAME_PAIRS pairs, then drains and
//  reports done.
// PARAMETERS
//  DATA_W      16     width of each I and Q sample and of out_data
//  FIFO_DEPTH  8      pair FIFO depth; power of 2, >=2
//  FRAME_PAIRS 10230  pairs per frame (20460 output words)
// PORTS
//  clk        in   1       single clock, posedge
//  reset      in   1       asynchronous, active-low; 0 = reset
//  start      in   1       pulse: begin (or restart) a frame
//  in_valid   in   1       in_i/in_q hold a new pair this cycle
//  in_i       in   DATA_W  I sample (from transmitter signal_sca_i)
//  in_q       in   DATA_W  Q sample (from transmitter signal_sca_q)
//  out_valid  out  1       out_data valid
//  out_ready  in   1       sink accepts out_data when out_valid&out_ready
//  out_data   out  DATA_W  I word (phase 0) or Q word (phase 1)
//  out_last   out  1       high on Q word of final frame pair
//  busy       out  1       state RUN or DRAIN
//  done       out  1       frame complete; held until next start
//  overflow   out  1       sticky: >=1 pair dropped this frame
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE; FIFO empty; phase=0; pair count=0.
//    All outputs 0 (out_valid, out_data, out_last, busy, done, overflow).
//  - FSM: IDLE -start-> RUN -(accepted==FRAME_PAIRS)-> DRAIN -(FIFO empty & last word taken)-> DONE.
//    DONE -start-> RUN. start in RUN/DRAIN restarts: FIFO flushed, phase=0, count=0,
//    overflow=0, done=0, next state RUN.
//  - in_valid in the start cycle is ignored. Inputs ignored in IDLE, DRAIN, DONE.
//  - Push (RUN, in_valid): pair written when FIFO not full, or full with a pair pop the same
//    cycle. Otherwise pair dropped; overflow set. Dropped pairs do not count toward FRAME_PAIRS.
//  - Latency: pair pushed in cycle n -> out_valid=1 at cycle n+1 (registered, no fall-through).
//  - Output: out_valid = FIFO non-empty.
//    phase 0: out_data = head I; phase 1: out_data = head Q.
//    Handshake in phase 0 -> phase 1. Handshake in phase 1 -> phase 0 and pop.
//    out_data/out_last stable while out_valid & !out_ready. out_data=0 when out_valid=0.
//  - out_last=1 only in phase 1 of pair number FRAME_PAIRS (1-based).
//    That handshake moves DRAIN->DONE; done=1 the next cycle.
//  - Pair counter width $clog2(FRAME_PAIRS+1); saturates at FRAME_PAIRS, no wrap.
//  - busy = (state==RUN || state==DRAIN).
// CONFIGURATION
//  IQ_PACKER_OVF_CNT_EN defined:
//    extra port ovf_count out 16: count of dropped pairs this frame.
//    Saturates at 16'hFFFF. Cleared by reset and start.
//  Not defined: port absent; drops reported only via sticky overflow.
// TESTING
//  1 reset=0 mid-traffic -> all outputs 0 immediately (async), state IDLE; no out_valid
//    until start after release.
//  2 FRAME_PAIRS=4, out_ready=1, start, then pairs (0001,8001),(0002,8002),(0003,8003),(0004,8004)
//    -> words 0001,8001,...,0004,8004; out_last only on 8004; done=1 next cycle; busy=0.
//  3 out_ready=0, push 9 pairs back-to-back into DEPTH 8 -> 8 stored, 9th dropped, overflow=1
//    (ovf_count=1 with macro). Then out_ready=1 -> 16 words in order.
//  4 out_ready toggled 1,0,0,1 around one pair -> I word held stable 2 stall cycles;
//    Q follows; no duplicates or loss.
//  5 Full FIFO, same-cycle Q handshake and in_valid -> pair accepted, no overflow.
//  6 start mid-RUN with 3 pairs queued -> FIFO flushed, out_valid=0 next cycle, count restarts,
//    overflow cleared.

Source files
------------

// File: rtl/iq_stream_packer.sv
// iq_stream_packer: buffers parallel I/Q pairs and emits them as an interleaved I,Q word stream for one frame.
// Latency: a pair pushed in cycle n shows its I word on out_data in cycle n+1; no fall-through path.
// Backpressure: out_ready low holds the current word; pairs arriving on a full FIFO are dropped and flagged.
// Build option: define IQ_PACKER_OVF_CNT_EN to add the 16-bit ovf_count port (dropped pairs this frame).
module iq_stream_packer #(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int FRAME_PAIRS = 10230
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_i,
  input  logic [DATA_W-1:0] in_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              overflow
`ifdef IQ_PACKER_OVF_CNT_EN
  ,
  output logic [15:0]       ovf_count
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FRAME_PAIRS + 1);

  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   FILL_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   FILL_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] PAIRS_ONE  = CW'(1);
  localparam logic [CW-1:0] PAIRS_MAX  = CW'(FRAME_PAIRS);
  localparam logic [CW-1:0] PAIRS_LAST = CW'(FRAME_PAIRS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e              state_q;
  logic                busy_q;
  logic                done_q;
  logic                overflow_q;
  logic                phase_q;
  logic [CW-1:0]       pairs_q, pairs_d;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         fill_q, fill_d;
  logic [2*DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [2*DATA_W-1:0] head_w;

  logic fifo_empty, fifo_full;
  logic hs, pop, push, drop, last_word;

  assign fifo_empty = (fill_q == '0);
  assign fifo_full  = (fill_q == FILL_FULL);
  assign head_w     = mem_q[rd_ptr_q];

  // A start cycle flushes everything, so neither side of the FIFO moves in it.
  assign hs   = !fifo_empty && out_ready && !start;
  assign pop  = hs && phase_q;
  assign push = (state_q == S_RUN) && in_valid && !start && (!fifo_full || pop);
  assign drop = (state_q == S_RUN) && in_valid && !start && fifo_full && !pop;

  // Pushes stop once the frame is complete, so in DRAIN the only entry left
  // at fill==1 is the frame's final pair.
  assign last_word = (state_q == S_DRAIN) && phase_q && (fill_q == FILL_ONE);

  assign out_valid = !fifo_empty;
  assign out_last  = last_word;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;

  // Present the head I word in phase 0 and the head Q word in phase 1; zero when empty.
  always_comb begin
    out_data = '0;
    if (!fifo_empty) begin
      out_data = phase_q ? head_w[DATA_W-1:0] : head_w[2*DATA_W-1:DATA_W];
    end
  end

  // Next FIFO occupancy and saturating accepted-pair count.
  always_comb begin
    fill_d  = fill_q;
    pairs_d = pairs_q;
    if (push && !pop) begin
      fill_d = fill_q + FILL_ONE;
    end else if (pop && !push) begin
      fill_d = fill_q - FILL_ONE;
    end
    if (push && (pairs_q != PAIRS_MAX)) begin
      pairs_d = pairs_q + PAIRS_ONE;
    end
  end

  // Pair storage; {I,Q} packed per entry, no reset needed since out_data is gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_i, in_q};
    end
  end

  // Frame FSM with FIFO pointers, word phase and registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      phase_q    <= 1'b0;
      pairs_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
    end else if (start) begin
      state_q    <= S_RUN;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      phase_q    <= 1'b0;
      pairs_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (hs)   phase_q  <= !phase_q;
      if (drop) overflow_q <= 1'b1;
      fill_q  <= fill_d;
      pairs_q <= pairs_d;
      case (state_q)
        S_RUN: begin
          if (push && (pairs_q == PAIRS_LAST)) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (hs && last_word) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef IQ_PACKER_OVF_CNT_EN
  logic [15:0] ovf_count_q;

  // Count dropped pairs in the current frame, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_count_q <= '0;
    end else if (start) begin
      ovf_count_q <= '0;
    end else if (drop && (ovf_count_q != 16'hFFFF)) begin
      ovf_count_q <= ovf_count_q + 16'd1;
    end
  end

  assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_iq_stream_packer.sv
`timescale 1ns/1ps
// Bench for iq_stream_packer: two instances (4-pair and 12-pair frames, depth 8) share one stimulus.
module tb_iq_stream_packer;

  localparam int ST_IDLE = 0, ST_RUN = 1, ST_DRAIN = 2, ST_DONE = 3;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [15:0] in_i, in_q;
  logic        out_ready;

  logic [1:0]  o_vld, o_last, o_busy, o_done, o_ovf;
  logic [15:0] o_dat [2];
  logic [15:0] o_ovc [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] capw [2][$];
  bit          capl [2][$];

  // Behavioural model state per instance: frame length, pair list, emitted pairs.
  int          fp [2] = '{4, 12};
  int          mst [2];
  int          mn [2];
  logic [31:0] mbuf [2][8];
  bit          mph [2];
  int          macc [2];
  int          mout [2];
  bit          movf [2];
  int          movc [2];

  logic [15:0] exp2 [8] = '{16'h0001, 16'h8001, 16'h0002, 16'h8002,
                            16'h0003, 16'h8003, 16'h0004, 16'h8004};

  iq_stream_packer #(.DATA_W(16), .FIFO_DEPTH(8), .FRAME_PAIRS(4)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_i(in_i), .in_q(in_q), .out_valid(o_vld[0]), .out_ready(out_ready),
    .out_data(o_dat[0]), .out_last(o_last[0]), .busy(o_busy[0]),
    .done(o_done[0]), .overflow(o_ovf[0])
`ifdef IQ_PACKER_OVF_CNT_EN
    , .ovf_count(o_ovc[0])
`endif
  );

  iq_stream_packer #(.DATA_W(16), .FIFO_DEPTH(8), .FRAME_PAIRS(12)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_i(in_i), .in_q(in_q), .out_valid(o_vld[1]), .out_ready(out_ready),
    .out_data(o_dat[1]), .out_last(o_last[1]), .busy(o_busy[1]),
    .done(o_done[1]), .overflow(o_ovf[1])
`ifdef IQ_PACKER_OVF_CNT_EN
    , .ovf_count(o_ovc[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model outputs, derived from the pair list and emitted-pair count.
  function automatic logic [31:0] m_vld(input int k);
    return (mn[k] > 0) ? 32'd1 : 32'd0;
  endfunction
  function automatic logic [31:0] m_dat(input int k);
    if (mn[k] == 0) return 32'd0;
    return mph[k] ? {16'h0, mbuf[k][0][15:0]} : {16'h0, mbuf[k][0][31:16]};
  endfunction
  function automatic logic [31:0] m_last(input int k);
    return (mn[k] > 0 && mph[k] && (mout[k] + 1 == fp[k])) ? 32'd1 : 32'd0;
  endfunction

  task automatic mstep(input int k);
    bit v, h, popq, lastw, full;
    if (start) begin
      mst[k] = ST_RUN; mn[k] = 0; mph[k] = 0; macc[k] = 0;
      mout[k] = 0; movf[k] = 0; movc[k] = 0;
      return;
    end
    v     = (mn[k] > 0);
    h     = v && out_ready;
    full  = (mn[k] == 8);
    popq  = h && mph[k];
    lastw = v && mph[k] && (mout[k] + 1 == fp[k]);
    if (h) mph[k] = !mph[k];
    if (popq) begin
      for (int j = 0; j < 7; j++) mbuf[k][j] = mbuf[k][j+1];
      mn[k]--;
      mout[k]++;
    end
    if (mst[k] == ST_RUN && in_valid) begin
      if (!full || popq) begin
        mbuf[k][mn[k]] = {in_i, in_q};
        mn[k]++;
        macc[k]++;
      end else begin
        movf[k] = 1;
        if (movc[k] < 65535) movc[k]++;
      end
    end
    if (mst[k] == ST_RUN && macc[k] == fp[k]) mst[k] = ST_DRAIN;
    else if (mst[k] == ST_DRAIN && h && lastw) mst[k] = ST_DONE;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        mst[k] = ST_IDLE; mn[k] = 0; mph[k] = 0; macc[k] = 0;
        mout[k] = 0; movf[k] = 0; movc[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) mstep(k);
    end
  end

  // Compare every instance against the model each cycle and record accepted words.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d_out_valid", k), 32'(o_vld[k]), m_vld(k));
      chk($sformatf("u%0d_out_data", k), 32'(o_dat[k]), m_dat(k));
      chk($sformatf("u%0d_out_last", k), 32'(o_last[k]), m_last(k));
      chk($sformatf("u%0d_busy", k), 32'(o_busy[k]),
          (mst[k] == ST_RUN || mst[k] == ST_DRAIN) ? 32'd1 : 32'd0);
      chk($sformatf("u%0d_done", k), 32'(o_done[k]), (mst[k] == ST_DONE) ? 32'd1 : 32'd0);
      chk($sformatf("u%0d_overflow", k), 32'(o_ovf[k]), 32'(movf[k]));
`ifdef IQ_PACKER_OVF_CNT_EN
      chk($sformatf("u%0d_ovf_count", k), 32'(o_ovc[k]), 32'(movc[k]));
`endif
      if (reset && o_vld[k] && out_ready && !start) begin
        capw[k].push_back(o_dat[k]);
        capl[k].push_back(o_last[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int k, input int budget, input string name);
    for (int c = 0; c < budget && o_done[k] == 1'b0; c++) tick();
    chk(name, 32'(o_done[k]), 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input int i, input int q);
    in_valid = 1'b1;
    in_i = 16'(i);
    in_q = 16'(q);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int nl;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    in_i = '0; in_q = '0; out_ready = 1'b0;
    repeat (3) tick();
    // Reset state
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", 32'(o_vld[k]), 0);
      chk("rst_data", 32'(o_dat[k]), 0);
      chk("rst_last", 32'(o_last[k]), 0);
      chk("rst_busy", 32'(o_busy[k]), 0);
      chk("rst_done", 32'(o_done[k]), 0);
      chk("rst_ovf", 32'(o_ovf[k]), 0);
    end
    reset = 1'b1;
    tick();

    // Four-pair frame at full rate; in_valid in the start cycle must be ignored
    capw[0].delete(); capl[0].delete();
    out_ready = 1'b1;
    in_valid = 1'b1; in_i = 16'hFFFF; in_q = 16'hFFFF;
    pulse_start();
    for (int k = 1; k <= 4; k++) push(k, 'h8000 + k);
    in_valid = 1'b0;
    wait_done(0, 40, "t2_done");
    chk("t2_nwords", capw[0].size(), 8);
    nl = 0;
    for (int j = 0; j < 8 && j < capw[0].size(); j++) begin
      chk("t2_word", 32'(capw[0][j]), 32'(exp2[j]));
      chk("t2_last", 32'(capl[0][j]), (j == 7) ? 32'd1 : 32'd0);
      nl += int'(capl[0][j]);
    end
    chk("t2_nlast", nl, 1);
    chk("t2_busy", 32'(o_busy[0]), 0);

    // Nine pairs into depth 8 while stalled: ninth is dropped
    out_ready = 1'b0;
    pulse_start();
    for (int k = 1; k <= 9; k++) push('h0100 + k, 'h0200 + k);
    in_valid = 1'b0;
    chk("t3_ovf", 32'(o_ovf[1]), 1);
    chk("t3_a_no_ovf", 32'(o_ovf[0]), 0);
`ifdef IQ_PACKER_OVF_CNT_EN
    chk("t3_ovf_count", 32'(o_ovc[1]), 1);
`endif
    capw[1].delete(); capl[1].delete();
    out_ready = 1'b1;
    repeat (20) tick();
    chk("t3_nwords", capw[1].size(), 16);
    for (int j = 0; j < 16 && j < capw[1].size(); j++)
      chk("t3_word", 32'(capw[1][j]), (j % 2 == 0) ? 32'('h0100 + j/2 + 1) : 32'('h0200 + j/2 + 1));

    // Stall around a single pair: I word held for two cycles
    pulse_start();
    capw[0].delete(); capl[0].delete(); capw[1].delete(); capl[1].delete();
    push('h0AAA, 'h0BBB);
    in_valid = 1'b0;
    chk("t4_hold0", 32'(o_dat[0]), 'h0AAA);
    out_ready = 1'b0;
    tick();
    chk("t4_hold1", 32'(o_dat[0]), 'h0AAA);
    tick();
    chk("t4_hold2", 32'(o_dat[0]), 'h0AAA);
    chk("t4_hold2_vld", 32'(o_vld[0]), 1);
    out_ready = 1'b1;
    tick();
    chk("t4_q", 32'(o_dat[0]), 'h0BBB);
    tick();
    chk("t4_empty", 32'(o_vld[0]), 0);
    for (int k = 0; k < 2; k++) begin
      chk("t4_nwords", capw[k].size(), 2);
      if (capw[k].size() == 2) begin
        chk("t4_w0", 32'(capw[k][0]), 'h0AAA);
        chk("t4_w1", 32'(capw[k][1]), 'h0BBB);
      end
    end

    // Full FIFO with a Q handshake and a new pair in the same cycle
    out_ready = 1'b0;
    pulse_start();
    for (int k = 1; k <= 8; k++) push('h0300 + k, 'h0400 + k);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("t5_q_head", 32'(o_dat[1]), 'h0401);
    push('h0309, 'h0409);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t5_no_ovf", 32'(o_ovf[1]), 0);
    chk("t5_head", 32'(o_dat[1]), 'h0302);
    capw[1].delete(); capl[1].delete();
    out_ready = 1'b1;
    repeat (20) tick();
    chk("t5_nwords", capw[1].size(), 16);
    for (int j = 0; j < 16 && j < capw[1].size(); j++)
      chk("t5_word", 32'(capw[1][j]), (j % 2 == 0) ? 32'('h0300 + j/2 + 2) : 32'('h0400 + j/2 + 2));

    // Restart mid-frame with three pairs queued and overflow set
    out_ready = 1'b0;
    pulse_start();
    for (int k = 1; k <= 9; k++) push('h0500 + k, 'h0600 + k);
    in_valid = 1'b0;
    chk("t6_ovf_set", 32'(o_ovf[1]), 1);
    out_ready = 1'b1;
    repeat (10) tick();
    out_ready = 1'b0;
    chk("t6_head", 32'(o_dat[1]), 'h0506);
    pulse_start();
    chk("t6_flush_vld", 32'(o_vld[1]), 0);
    chk("t6_ovf_clr", 32'(o_ovf[1]), 0);
    chk("t6_busy", 32'(o_busy[1]), 1);
    chk("t6_done", 32'(o_done[1]), 0);
`ifdef IQ_PACKER_OVF_CNT_EN
    chk("t6_ovf_count_clr", 32'(o_ovc[1]), 0);
`endif
    capw[1].delete(); capl[1].delete();
    out_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      push('h0700 + k, 'h0780 + k);
      in_valid = 1'b0;
      tick();
    end
    wait_done(1, 40, "t6_frame_done");
    chk("t6_nwords", capw[1].size(), 24);
    if (capw[1].size() == 24) begin
      chk("t6_first", 32'(capw[1][0]), 'h0701);
      chk("t6_lastword", 32'(capw[1][23]), 'h078C);
      chk("t6_lastflag", 32'(capl[1][23]), 1);
      chk("t6_prelast", 32'(capl[1][22]), 0);
    end
    chk("t6_no_ovf", 32'(o_ovf[1]), 0);

    // Asynchronous reset in the middle of traffic
    out_ready = 1'b1;
    pulse_start();
    push('h0901, 'h0902);
    push('h0903, 'h0904);
    chk("t1_pre_vld", 32'(o_vld[0]), 1);
    #1 reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("t1_vld", 32'(o_vld[k]), 0);
      chk("t1_data", 32'(o_dat[k]), 0);
      chk("t1_last", 32'(o_last[k]), 0);
      chk("t1_busy", 32'(o_busy[k]), 0);
      chk("t1_done", 32'(o_done[k]), 0);
      chk("t1_ovf", 32'(o_ovf[k]), 0);
    end
    repeat (2) tick();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      push('h0A00 + c, 'h0B00 + c);
      chk("t1_idle_vld_a", 32'(o_vld[0]), 0);
      chk("t1_idle_vld_b", 32'(o_vld[1]), 0);
      chk("t1_idle_busy", 32'(o_busy[0]), 0);
    end
    in_valid = 1'b0;
    pulse_start();
    push('h0C01, 'h0C02);
    in_valid = 1'b0;
    chk("t1_resume_vld", 32'(o_vld[0]), 1);
    chk("t1_resume_dat", 32'(o_dat[0]), 'h0C01);
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
